// File: rtl/window_control.sv
// window_control: current-window pointer, WIM, ET/S/PS and latched window-trap request.
// Optional macro WINDOW_CHECK_EN enables WIM checks for SAVE, RESTORE and RETT.
`default_nettype none

module window_control #(
    parameter int NWIN = 4
) (
    input  logic                     Clk,
    input  logic                     Clr,
    input  logic                     save,
    input  logic                     restore,
    input  logic                     trap_entry,
    input  logic                     rett,
    input  logic                     wr_cwp,
    input  logic [$clog2(NWIN)-1:0]  cwp_in,
    input  logic                     wr_wim,
    input  logic [NWIN-1:0]          wim_in,
    input  logic                     trap_ack,
    output logic [$clog2(NWIN)-1:0]  current_window,
    output logic [NWIN-1:0]          wim,
    output logic                     et,
    output logic                     s,
    output logic                     ps,
    output logic                     trap_req,
    output logic [5:0]               trap_tt
);

    localparam int              CW          = $clog2(NWIN);
    localparam logic [CW-1:0]   C_ONE       = CW'(1);
    localparam logic [5:0]      C_TT_ILLEGAL = 6'h02;
    localparam logic [5:0]      C_TT_PRIV    = 6'h03;
    localparam logic [5:0]      C_TT_OVF     = 6'h05;
    localparam logic [5:0]      C_TT_UNF     = 6'h06;

    logic [CW-1:0]   r_cwp;
    logic [NWIN-1:0] r_wim;
    logic            r_et;
    logic            r_s;
    logic            r_ps;
    logic            r_trap_req;
    logic [5:0]      r_trap_tt;

    logic [CW-1:0]   w_cwp_dec;
    logic [CW-1:0]   w_cwp_inc;
    logic            w_dec_invalid;
    logic            w_inc_invalid;

    assign w_cwp_dec = r_cwp - C_ONE;
    assign w_cwp_inc = r_cwp + C_ONE;

    // Checks always use the WIM value held before this edge, so a same-cycle WIM write is not seen.
`ifdef WINDOW_CHECK_EN
    assign w_dec_invalid = r_wim[w_cwp_dec];
    assign w_inc_invalid = r_wim[w_cwp_inc];
`else
    assign w_dec_invalid = 1'b0;
    assign w_inc_invalid = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_cwp      <= '0;
            r_wim      <= '0;
            r_et       <= 1'b0;
            r_s        <= 1'b1;
            r_ps       <= 1'b0;
            r_trap_req <= 1'b0;
            r_trap_tt  <= 6'h00;
        end else begin
            if (wr_wim) begin
                r_wim <= wim_in;
            end
            if (trap_ack) begin
                r_trap_req <= 1'b0;
            end

            if (trap_entry) begin
                r_cwp      <= w_cwp_dec;
                r_et       <= 1'b0;
                r_ps       <= r_s;
                r_s        <= 1'b1;
                r_trap_req <= 1'b0;
            end else if (!r_trap_req) begin
                // A pending trap blocks every remaining window operation.
                if (rett) begin
                    if (r_et) begin
                        r_trap_req <= 1'b1;
                        r_trap_tt  <= r_s ? C_TT_ILLEGAL : C_TT_PRIV;
                    end else if (w_inc_invalid) begin
                        r_trap_req <= 1'b1;
                        r_trap_tt  <= C_TT_UNF;
                    end else begin
                        r_cwp <= w_cwp_inc;
                        r_et  <= 1'b1;
                        r_s   <= r_ps;
                    end
                end else if (save) begin
                    if (w_dec_invalid) begin
                        r_trap_req <= 1'b1;
                        r_trap_tt  <= C_TT_OVF;
                    end else begin
                        r_cwp <= w_cwp_dec;
                    end
                end else if (restore) begin
                    if (w_inc_invalid) begin
                        r_trap_req <= 1'b1;
                        r_trap_tt  <= C_TT_UNF;
                    end else begin
                        r_cwp <= w_cwp_inc;
                    end
                end else if (wr_cwp) begin
                    r_cwp <= cwp_in;
                end
            end
        end
    end

    assign current_window = r_cwp;
    assign wim            = r_wim;
    assign et             = r_et;
    assign s              = r_s;
    assign ps             = r_ps;
    assign trap_req       = r_trap_req;
    assign trap_tt        = r_trap_tt;

endmodule

`default_nettype wire

// File: tb/tb_window_control.sv
// tb_window_control: directed test-plan steps followed by random traffic, checked against a behavioural model.
`default_nettype none

module tb_window_control;

    logic       Clk = 1'b0;
    logic       Clr, save, restore, trap_entry, rett, wr_cwp, wr_wim, trap_ack;
    logic [1:0] cwp_in;
    logic [3:0] wim_in;
    logic [1:0] current_window;
    logic [3:0] wim;
    logic       et, s, ps, trap_req;
    logic [5:0] trap_tt;

    int checks = 0;
    int errors = 0;

    // Reference state
    int         m_cwp;
    logic [3:0] m_wim;
    logic       m_et, m_s, m_ps, m_req;
    logic [5:0] m_tt;

`ifdef WINDOW_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    window_control #(.NWIN(4)) dut (
        .Clk(Clk), .Clr(Clr), .save(save), .restore(restore),
        .trap_entry(trap_entry), .rett(rett), .wr_cwp(wr_cwp), .cwp_in(cwp_in),
        .wr_wim(wr_wim), .wim_in(wim_in), .trap_ack(trap_ack),
        .current_window(current_window), .wim(wim), .et(et), .s(s), .ps(ps),
        .trap_req(trap_req), .trap_tt(trap_tt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Clr = 0; save = 0; restore = 0; trap_entry = 0; rett = 0;
        wr_cwp = 0; wr_wim = 0; trap_ack = 0; cwp_in = '0; wim_in = '0;
    endtask

    task automatic raise(input logic [5:0] tt, inout logic nreq);
        nreq = 1'b1;
        m_tt = tt;
    endtask

    // Next state from the architectural rules, using plain integer window arithmetic.
    task automatic model_step();
        logic [3:0] nw;
        logic       nreq;
        int         n;
        if (Clr) begin
            m_cwp = 0; m_wim = 4'b0000; m_et = 0; m_s = 1; m_ps = 0; m_req = 0; m_tt = 6'h00;
            return;
        end
        nw   = wr_wim ? wim_in : m_wim;
        nreq = trap_ack ? 1'b0 : m_req;
        if (trap_entry) begin
            m_cwp = (m_cwp + 3) % 4;
            m_ps  = m_s;
            m_s   = 1'b1;
            m_et  = 1'b0;
            nreq  = 1'b0;
        end else if (!m_req) begin
            if (rett) begin
                n = (m_cwp + 1) % 4;
                if (m_et) raise(m_s ? 6'h02 : 6'h03, nreq);
                else if (CHK_EN && m_wim[n]) raise(6'h06, nreq);
                else begin m_cwp = n; m_et = 1'b1; m_s = m_ps; end
            end else if (save) begin
                n = (m_cwp + 3) % 4;
                if (CHK_EN && m_wim[n]) raise(6'h05, nreq);
                else m_cwp = n;
            end else if (restore) begin
                n = (m_cwp + 1) % 4;
                if (CHK_EN && m_wim[n]) raise(6'h06, nreq);
                else m_cwp = n;
            end else if (wr_cwp) begin
                m_cwp = int'(cwp_in);
            end
        end
        m_wim = nw;
        m_req = nreq;
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
        chk("cwp",      32'(current_window), 32'(m_cwp));
        chk("wim",      32'(wim),            32'(m_wim));
        chk("et",       32'(et),             32'(m_et));
        chk("s",        32'(s),              32'(m_s));
        chk("ps",       32'(ps),             32'(m_ps));
        chk("trap_req", 32'(trap_req),       32'(m_req));
        chk("trap_tt",  32'(trap_tt),        32'(m_tt));
        idle();
    endtask

    initial begin
        idle();
        Clr = 1; tick();
        chk("rst_cwp", 32'(current_window), 0);
        chk("rst_s",   32'(s), 1);
        chk("rst_tt",  32'(trap_tt), 0);

        // Four SAVEs walk 3,2,1,0 with no trap
        save = 1; tick(); chk("save1", 32'(current_window), 3);
        save = 1; tick(); chk("save2", 32'(current_window), 2);
        save = 1; tick(); chk("save3", 32'(current_window), 1);
        save = 1; tick(); chk("save4", 32'(current_window), 0);
        chk("save_noreq", 32'(trap_req), 0);

        // Overflow on window 2, blocked RESTORE, then trap entry
        wr_wim = 1; wim_in = 4'b0100; tick();
        wr_cwp = 1; cwp_in = 2'd3; tick();
        save = 1; tick();
        chk("ovf_cwp", 32'(current_window), CHK_EN ? 3 : 2);
        chk("ovf_req", 32'(trap_req), CHK_EN ? 1 : 0);
        if (CHK_EN) chk("ovf_tt", 32'(trap_tt), 32'h05);
        restore = 1; tick();
        chk("blocked_restore", 32'(current_window), 3);
        trap_entry = 1; tick();
        chk("te_cwp", 32'(current_window), 2);
        chk("te_et",  32'(et), 0);
        chk("te_ps",  32'(ps), 1);
        chk("te_req", 32'(trap_req), 0);

        // Underflow on window 0 from CWP=3
        wr_wim = 1; wim_in = 4'b0001; tick();
        wr_cwp = 1; cwp_in = 2'd3; tick();
        restore = 1; tick();
        chk("unf_cwp", 32'(current_window), CHK_EN ? 3 : 0);
        if (CHK_EN) chk("unf_tt", 32'(trap_tt), 32'h06);
        trap_ack = 1; tick();
        chk("ack_req", 32'(trap_req), 0);

        // RETT / trap_entry / illegal RETT in user mode
        Clr = 1; tick();
        rett = 1; tick();
        chk("rett0_s", 32'(s), 0);
        chk("rett0_cwp", 32'(current_window), 1);
        trap_entry = 1; tick();
        chk("te2_cwp", 32'(current_window), 0);
        chk("te2_ps", 32'(ps), 0);
        chk("te2_s", 32'(s), 1);
        rett = 1; tick();
        chk("rett_cwp", 32'(current_window), 1);
        chk("rett_et", 32'(et), 1);
        chk("rett_s", 32'(s), 0);
        rett = 1; tick();
        chk("priv_tt", 32'(trap_tt), 32'h03);
        chk("priv_cwp", 32'(current_window), 1);
        trap_ack = 1; tick();

        // Priority: only SAVE honoured
        save = 1; restore = 1; wr_cwp = 1; cwp_in = 2'd2; tick();
        chk("prio_cwp", 32'(current_window), 0);
        wr_cwp = 1; cwp_in = 2'd2; tick();
        chk("wrcwp", 32'(current_window), 2);

        // Clr right after a trap is raised
        rett = 1; tick();
        chk("pre_clr_req", 32'(trap_req), 1);
        Clr = 1; save = 1; tick();
        chk("clr_req", 32'(trap_req), 0);
        chk("clr_cwp", 32'(current_window), 0);
        chk("clr_et", 32'(et), 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            Clr        = ($urandom_range(0, 59) == 0);
            save       = ($urandom_range(0, 2) == 0);
            restore    = ($urandom_range(0, 2) == 0);
            trap_entry = ($urandom_range(0, 7) == 0);
            rett       = ($urandom_range(0, 4) == 0);
            wr_cwp     = ($urandom_range(0, 5) == 0);
            cwp_in     = 2'($urandom_range(0, 3));
            wr_wim     = ($urandom_range(0, 4) == 0);
            wim_in     = 4'($urandom_range(0, 15));
            trap_ack   = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
